// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter shared definitions: bus field positions,
// FSM state encoding, owner codes and bus/response types.
package mem_bus_arbiter_pkg;

    localparam int BUS_W        = 66;
    localparam int RESP_W       = 33;

    localparam int BUS_REQ      = 65;
    localparam int BUS_WE       = 64;
    localparam int BUS_ADDR_HI  = 63;
    localparam int BUS_ADDR_LO  = 32;
    localparam int BUS_WDATA_HI = 31;
    localparam int BUS_WDATA_LO = 0;

    localparam int RESP_ACK     = 32;
    localparam int RESP_DATA_HI = 31;
    localparam int RESP_DATA_LO = 0;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef logic [BUS_W-1:0]  bus_t;
    typedef logic [RESP_W-1:0] resp_t;

    function automatic resp_t mk_resp(input logic [31:0] data);
        return {1'b1, data};
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_arb_grant_pick.sv
// Combinational 2-way grant picker (I-side vs D-side).
// Ports: req_i/req_d requests, last_owner, rr_mode -> grant_valid, grant_owner.
module arb_grant_pick
    import mem_bus_arbiter_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic last_owner,
    input  logic rr_mode,
    output logic grant_valid,
    output logic grant_owner
);

    always_comb begin
        grant_valid = req_i | req_d;
        grant_owner = OWNER_I;
        unique case ({req_i, req_d})
            2'b01:   grant_owner = OWNER_D;
            2'b10:   grant_owner = OWNER_I;
            // tie: round-robin hands it to whoever did not go last
            2'b11:   grant_owner = rr_mode ? ~last_owner : OWNER_D;
            default: grant_owner = OWNER_I;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between the I-cache and D-cache miss buses.
// Ports: Clk, Rst (async, high); i_icache_bus/i_dcache_bus requests in,
// o_icache_resp/o_dcache_resp responses out; o_mem_bus/i_mem_resp memory
// side; o_busy, o_owner, o_timeout status.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int RR_MODE        = 0,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TO_WIDTH       = 9
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [BUS_W-1:0]  i_icache_bus,
    output logic [RESP_W-1:0] o_icache_resp,
    input  logic [BUS_W-1:0]  i_dcache_bus,
    output logic [RESP_W-1:0] o_dcache_resp,
    output logic [BUS_W-1:0]  o_mem_bus,
    input  logic [RESP_W-1:0] i_mem_resp,
    output logic              o_busy,
    output logic              o_owner,
    output logic              o_timeout
);

    localparam logic WD_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_WIDTH-1:0] WD_LAST =
        TO_WIDTH'(TIMEOUT_CYCLES - 1);

    arb_state_e state_q, state_d;
    // req bit is regenerated from state, so only we/addr/wdata are held
    logic [BUS_WE:0]     req_q, req_d;
    logic                owner_q, owner_d;
    logic [TO_WIDTH-1:0] wd_q, wd_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                to_q, to_d;

    logic grant_valid;
    logic grant_owner;
    logic wd_expired;
    logic in_resp;

    arb_grant_pick u_pick (
        .req_i       (i_icache_bus[BUS_REQ]),
        .req_d       (i_dcache_bus[BUS_REQ]),
        .last_owner  (owner_q),
        .rr_mode     (RR_MODE != 0),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    assign wd_expired = WD_EN && (wd_q == WD_LAST);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            req_q   <= '0;
            owner_q <= OWNER_I;
            wd_q    <= '0;
            rdata_q <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            owner_q <= owner_d;
            wd_q    <= wd_d;
            rdata_q <= rdata_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        owner_d = owner_q;
        wd_d    = wd_q;
        rdata_d = rdata_q;
        to_d    = to_q;
        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d = BUSY;
                    owner_d = grant_owner;
                    req_d   = (grant_owner == OWNER_D)
                            ? i_dcache_bus[BUS_WE:0]
                            : i_icache_bus[BUS_WE:0];
                    wd_d    = '0;
                    to_d    = 1'b0;
                end
            end
            BUSY: begin
                // a real ack wins over a watchdog expiring the same cycle
                if (i_mem_resp[RESP_ACK]) begin
                    rdata_d = i_mem_resp[RESP_DATA_HI:RESP_DATA_LO];
                    to_d    = 1'b0;
                    state_d = RESP;
                end else if (wd_expired) begin
                    rdata_d = '0;
                    to_d    = 1'b1;
                    state_d = RESP;
                end else if (!(&wd_q)) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_resp   = (state_q == RESP);
    assign o_busy    = (state_q != IDLE);
    assign o_owner   = owner_q;
    assign o_timeout = in_resp && to_q;
    assign o_mem_bus = {state_q == BUSY, req_q};

    assign o_icache_resp = (in_resp && owner_q == OWNER_I)
                         ? mk_resp(rdata_q) : '0;
    assign o_dcache_resp = (in_resp && owner_q == OWNER_D)
                         ? mk_resp(rdata_q) : '0;

endmodule
